alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised successor to the 16-bit combinational ALU: WIDTH-generic, registered output
//  behind a valid/ready handshake, with added shift, unsigned-compare and iterative multiply ops.
//  Sits between decode/issue and writeback; the multiply stalls issue via in_ready.
//  Produces full flag set (zero/negative/carry/overflow).
// PARAMETERS
//  WIDTH    16  operand/result width, >= 4, power of two
//  SHW      $clog2(WIDTH)  shift-amount bits taken from b (derived, do not override)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands/op presented
//  in_ready   out  1      block can accept this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B (shift amount = b[SHW-1:0])
//  alu_op     in   4      operation select (encoding below)
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer accepts result
//  alu_result out  WIDTH  registered result
//  zero       out  1      alu_result == 0
//  negative   out  1      alu_result[WIDTH-1]
//  carry      out  1      see op table
//  overflow   out  1      signed overflow, see op table
// BEHAVIOUR
//  Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed, result 0/1), 6 SLL, 7 SRL,
//   8 SRA, 9 MUL (low WIDTH bits of unsigned product), 10 SLTU, 11-15 -> result 0, flags 0.
//  Flags: ADD carry=carry-out, overflow=signed ovf; SUB carry=borrow (a<b unsigned),
//   overflow=signed ovf; MUL carry=1 iff upper WIDTH product bits nonzero, overflow=0;
//   all other ops carry=overflow=0. zero/negative always derived from alu_result.
//  Handshake: accept = in_valid & in_ready. Output transfer = out_valid & out_ready.
//   in_ready = (state==IDLE) & (!out_valid | out_ready). Inputs sampled only at accept.
//   Result and flags held stable while out_valid & !out_ready.
//  FSM: IDLE -> (accept, op!=9) IDLE, output reg loaded at the accept edge: out_valid rises
//   1 cycle after accept. IDLE -> (accept, op==9) MUL: shift-add, one multiplier bit per cycle,
//   2*WIDTH-bit accumulator, bit counter 0..WIDTH-1. MUL -> IDLE on the step with counter ==
//   WIDTH-1, output reg loaded the same edge: out_valid rises WIDTH cycles after accept.
//   in_ready=0 throughout MUL. Output reg is empty by then (in_ready required it at accept).
//  Back-to-back: single-cycle ops sustain 1 op/cycle while out_ready=1.
//  Shifts: amount b[SHW-1:0] only, upper b bits ignored; amount 0 returns a. SRA sign-fills.
//  Arithmetic is modulo 2^WIDTH; SLT/SLTU results zero-extended to WIDTH.
//  Reset (async, any state incl. mid-MUL): state=IDLE, out_valid=0, alu_result=0, carry=0,
//   overflow=0, counter/accumulator=0; zero=1, negative=0 (derived). In-flight MUL discarded.
//   in_ready=1 after reset release.
//  out_valid never asserts without a preceding accept; each accept yields exactly one result.
// TESTING (WIDTH=16)
//  ADD a=7FFF b=0001, out_ready=1 -> next cycle result 8000, overflow=1, negative=1, carry=0
//  SUB a=0003 b=0005 -> FFFE, carry=1, overflow=0; SUB a=b=1234 -> 0000, zero=1
//  MUL a=0100 b=0300 -> in_ready low 16 cycles, out_valid 16 cycles after accept,
//   result 0000, carry=1, zero=1; MUL a=00FF b=0101 -> FFFF, carry=0
//  SRA a=8000 b=0014 (amount 4) -> F800; SLL a=0001 b=000F -> 8000; SLTU a=FFFF b=0001 -> 0000,
//   SLT same operands -> 0001
//  Backpressure: issue ADD then hold out_ready=0 3 cycles -> result/flags stable,
//   in_ready=0; release -> transfer once, next op accepted same cycle
//  Reset asserted 5 cycles into MUL -> out_valid=0 immediately, no result after release,
//   in_ready=1, zero=1

Source files
------------

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered ALU with valid/ready handshake and iterative shift-add multiply
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;

  typedef enum logic {IDLE, MUL} state_t;

  state_t               state, state_next;
  logic                 accept;
  logic                 load_single;
  logic                 mul_last;
  logic [SHW-1:0]       cnt;
  logic [WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       diff;
  logic [SHW-1:0]       sh;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c;
  logic                 alu_v;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept && alu_op == OP_MUL) state_next = MUL;
      MUL:  if (mul_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready    = (state == IDLE) && (!out_valid || out_ready);
    accept      = in_valid && in_ready;
    load_single = accept && (alu_op != OP_MUL);
    mul_last    = (state == MUL) && (cnt == SHW'(WIDTH - 1));
  end

  // single-cycle operations; diff[WIDTH] is the unsigned borrow
  always_comb begin
    sum     = {1'b0, a} + {1'b0, b};
    diff    = {1'b0, a} - {1'b0, b};
    sh      = b[SHW-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL:  alu_res = a << sh;
      OP_SRL:  alu_res = a >> sh;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> sh);
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  // one multiplier bit per cycle: add the multiplicand shifted to that bit's weight
  always_comb begin
    mul_addend = {{WIDTH{1'b0}}, mcand} << cnt;
    acc_next   = mplier[cnt] ? (acc + mul_addend) : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      out_valid  <= 1'b0;
      alu_result <= '0;
      carry      <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (accept && alu_op == OP_MUL) begin
        mcand  <= a;
        mplier <= b;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == MUL) begin
        acc <= acc_next;
        cnt <= cnt + SHW'(1);
      end

      if (load_single) begin
        out_valid  <= 1'b1;
        alu_result <= alu_res;
        carry      <= alu_c;
        overflow   <= alu_v;
      end else if (mul_last) begin
        out_valid  <= 1'b1;
        alu_result <= acc_next[WIDTH-1:0];
        carry      <= |acc_next[2*WIDTH-1:WIDTH];
        overflow   <= 1'b0;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end
    end
  end

  assign zero     = (alu_result == '0);
  assign negative = alu_result[WIDTH-1];

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench for alu_pipe against an integer-arithmetic reference model
module tb_alu_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   alu_op = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] alu_result;
  logic         zero, negative, carry, overflow;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .zero(zero), .negative(negative),
    .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         op;
    logic [W-1:0] res;
    logic       c;
    logic       v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int op, input longint ua, input longint ub);
    exp_t   e;
    longint sa, sb_, r, sh;
    sa  = (ua >= 32768) ? ua - 65536 : ua;
    sb_ = (ub >= 32768) ? ub - 65536 : ub;
    sh  = ub % 16;
    e.op = op; e.c = 1'b0; e.v = 1'b0; r = 0;
    case (op)
      0: begin r = ua + ub; e.c = (r > 65535); e.v = ((sa + sb_) > 32767) || ((sa + sb_) < -32768); end
      1: begin r = ua - ub + 65536; e.c = (ua < ub); e.v = ((sa - sb_) > 32767) || ((sa - sb_) < -32768); end
      2: r = ua & ub;
      3: r = ua | ub;
      4: r = ua ^ ub;
      5: r = (sa < sb_) ? 1 : 0;
      6: r = ua * (longint'(1) << sh);
      7: r = ua / (longint'(1) << sh);
      8: r = (sa >>> sh) + 65536;
      9: begin r = ua * ub; e.c = (r >= 65536); end
      10: r = (ua < ub) ? 1 : 0;
      default: r = 0;
    endcase
    e.res = W'(r % 65536);
    return e;
  endfunction

  always @(negedge clk) begin
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // monitor: every output transfer pops one expected entry
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("op%0d_result", e.op), alu_result, e.res);
        chk($sformatf("op%0d_flags_zncv", e.op), {zero, negative, carry, overflow},
            {(e.res == 0), e.res[W-1], e.c, e.v});
      end
    end
  end

  task automatic issue(input int op, input logic [W-1:0] va, input logic [W-1:0] vb,
                       output int waits);
    @(negedge clk);
    in_valid = 1'b1; alu_op = 4'(op); a = va; b = vb;
    waits = 0;
    #1;
    while (!in_ready) begin
      if (waits > 200) begin
        chk("issue_timeout", waits, 0);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk); #1;
      waits++;
    end
    sb.push_back(model(op, longint'(va), longint'(vb)));
  endtask

  task automatic go_idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  int           w, lows, cyc, bad;
  logic [W-1:0] held;
  logic [3:0]   held_f;
  logic [W-1:0] ra, rb;

  initial begin
    repeat (3) @(negedge clk);
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", alu_result, 0);
    chk("rst_flags_zncv", {zero, negative, carry, overflow}, 4'b1000);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // single-cycle latency: ADD overflow into sign bit
    issue(0, 16'h7FFF, 16'h0001, w);
    go_idle(); #3;
    chk("add_latency_valid", out_valid, 1);

    issue(1, 16'h0003, 16'h0005, w);
    issue(1, 16'h1234, 16'h1234, w);
    issue(8, 16'h8000, 16'h0014, w);
    issue(6, 16'h0001, 16'h000F, w);
    issue(10, 16'hFFFF, 16'h0001, w);
    issue(5, 16'hFFFF, 16'h0001, w);
    chk("back_to_back_waits", w, 0);
    go_idle();

    // MUL: in_ready low and out_valid arriving WIDTH cycles after accept
    issue(9, 16'h0100, 16'h0300, w);
    lows = 0; cyc = 0;
    @(negedge clk); in_valid = 1'b0; #3;
    while (!out_valid && cyc < 100) begin
      cyc++;
      if (!in_ready) lows++;
      @(negedge clk); #3;
    end
    chk("mul_latency", cyc, W);
    chk("mul_in_ready_low", lows, W);
    issue(9, 16'h00FF, 16'h0101, w);
    go_idle();

    // backpressure: result held while consumer stalls
    issue(0, 16'h1111, 16'h2222, w);
    ready_mode = 2;
    @(negedge clk); in_valid = 1'b0; #3;
    held = alu_result; held_f = {zero, negative, carry, overflow};
    chk("bp_valid", out_valid, 1);
    chk("bp_in_ready", in_ready, 0);
    bad = 0;
    repeat (2) begin
      @(negedge clk); #3;
      if (!out_valid || in_ready || alu_result != held ||
          {zero, negative, carry, overflow} != held_f) bad++;
    end
    chk("bp_stable", bad, 0);
    chk("bp_held_result", held, 16'h3333);
    ready_mode = 0;
    issue(4, 16'hA5A5, 16'h0FF0, w);
    chk("bp_release_accept_same_cycle", w, 0);
    go_idle();
    repeat (3) @(negedge clk);

    // reset mid-multiply discards the in-flight result
    issue(9, 16'h1234, 16'h5678, w);
    go_idle();
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midmul_rst_out_valid", out_valid, 0);
    chk("midmul_rst_zero", zero, 1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midmul_rst_in_ready", in_ready, 1);
    bad = 0;
    repeat (25) begin
      @(negedge clk); #3;
      if (out_valid) bad++;
    end
    chk("midmul_no_result", bad, 0);

    // randomized traffic with random consumer stalls
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 5))
        0: ra = 16'h7FFF;
        1: ra = 16'h8000;
        2: rb = 16'hFFFF;
        default: ;
      endcase
      issue(int'($urandom_range(0, 15)), ra, rb, w);
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();
    ready_mode = 0;
    cyc = 0;
    while (sb.size() != 0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
